// File: rtl/fpalu_arbiter_if.sv
// fpalu_arbiter_if: requester-side request/response bus of the shared FPALU arbiter
interface fpalu_arbiter_if #(
    parameter int NREQ = 3,
    parameter int DW = 29
);
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_lock;
    logic [2*NREQ-1:0] req_opcode;
    logic [DW*NREQ-1:0] req_a;
    logic [DW*NREQ-1:0] req_b;
    logic [NREQ-1:0] req_ready;
    logic [NREQ-1:0] rsp_valid;
    logic [DW-1:0] rsp_data;
    modport master (
        output req_valid, req_lock, req_opcode, req_a, req_b,
        input  req_ready, rsp_valid, rsp_data
    );
    modport slave (
        input  req_valid, req_lock, req_opcode, req_a, req_b,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/fpalu_arbiter.sv
// fpalu_arbiter: round-robin arbiter with lockable bursts sharing one pipelined FPALU
module fpalu_arbiter #(
    parameter int NREQ = 3,
    parameter int DW = 29,
    parameter int LATENCY = 4,
    parameter int LOCK_MAX = 64
) (
    input  logic clk,
    input  logic rst,
    fpalu_arbiter_if.slave bus,
    output logic alu_issue,
    output logic [1:0] alu_opcode,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_y,
    output logic err_lock_timeout
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);
    typedef enum logic {ARB, LOCKED} state_t;
    state_t state, state_nx;
    logic [IW-1:0] rr_ptr, rr_nx, owner, owner_nx, win, idx, grant;
    logic [CW-1:0] lock_cnt, cnt_nx;
    logic found, accept, lock, cap, timeout;
    logic [1:0] sel_op;
    logic [DW-1:0] sel_a, sel_b;
    logic [LATENCY:0] tag_v;
    logic [LATENCY:0][IW-1:0] tag_id;

    // scan downwards so the requester closest to rr_ptr is the last one written
    always_comb begin
        win = '0;
        found = 1'b0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IW'((int'(rr_ptr) + k) % NREQ);
            if (bus.req_valid[idx]) begin
                win = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        grant = state == LOCKED ? owner : win;
        accept = !rst && (state == LOCKED ? bus.req_valid[owner] : found);
        bus.req_ready = accept ? ONE << grant : '0;
        lock = bus.req_lock[grant];
        cap = lock_cnt == CW'(LOCK_MAX - 1);
        timeout = accept && state == LOCKED && lock && cap;
        state_nx = accept ? (lock && !timeout ? LOCKED : ARB) : state;
        rr_nx = accept && state == ARB ? IW'((int'(grant) + 1) % NREQ) : rr_ptr;
        owner_nx = accept && state == ARB ? grant : owner;
        cnt_nx = state_nx == ARB ? '0 : accept ? (state == ARB ? CW'(1) : lock_cnt + CW'(1)) : lock_cnt;
        sel_op = '0;
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant == IW'(i)) begin
                sel_op = bus.req_opcode[2*i +: 2];
                sel_a = bus.req_a[DW*i +: DW];
                sel_b = bus.req_b[DW*i +: DW];
            end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB;
            rr_ptr <= '0;
            owner <= '0;
            lock_cnt <= '0;
            err_lock_timeout <= 1'b0;
            alu_issue <= 1'b0;
            alu_opcode <= '0;
            alu_a <= '0;
            alu_b <= '0;
            tag_v <= '0;
            tag_id <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_data <= '0;
        end else begin
            state <= state_nx;
            rr_ptr <= rr_nx;
            owner <= owner_nx;
            lock_cnt <= cnt_nx;
            err_lock_timeout <= err_lock_timeout | timeout;
            alu_issue <= accept;
            if (accept) begin
                alu_opcode <= sel_op;
                alu_a <= sel_a;
                alu_b <= sel_b;
            end
            tag_v <= {tag_v[LATENCY-1:0], accept};
            tag_id <= {tag_id[LATENCY-1:0], grant};
            bus.rsp_valid <= tag_v[LATENCY] ? ONE << tag_id[LATENCY] : '0;
            if (tag_v[LATENCY]) bus.rsp_data <= alu_y;
        end
    end
endmodule

// File: tb/tb_fpalu_arbiter.sv
// tb_fpalu_arbiter: random and directed traffic checked against a queue-based arbiter model
module tb_fpalu_arbiter;
    localparam int NREQ = 3;
    localparam int DW = 29;
    localparam int LATENCY = 4;
    localparam int LOCK_MAX = 5;

    typedef struct {
        int due;
        int id;
        logic [DW-1:0] y;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic alu_issue, err_lock_timeout;
    logic [1:0] alu_opcode;
    logic [DW-1:0] alu_a, alu_b, alu_y;
    logic [DW-1:0] alu_pipe [LATENCY];
    logic [1:0] op_c [NREQ];
    logic [DW-1:0] op_a [NREQ];
    logic [DW-1:0] op_b [NREQ];
    bit rand_ops = 1'b1;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ptr = 0;
    int owner = 0;
    int cnt = 0;
    bit locked = 1'b0;
    bit m_err = 1'b0;
    bit m_issue = 1'b0;
    logic [1:0] m_op = '0;
    logic [DW-1:0] m_a = '0;
    logic [DW-1:0] m_b = '0;
    rsp_t rq[$];
    int last_g;

    always #5 clk = ~clk;

    fpalu_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    fpalu_arbiter #(.NREQ(NREQ), .DW(DW), .LATENCY(LATENCY), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .alu_issue(alu_issue),
        .alu_opcode(alu_opcode),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_y(alu_y),
        .err_lock_timeout(err_lock_timeout)
    );

    function automatic logic [DW-1:0] alu_fn(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        return op == 2'd0 ? a + b : op == 2'd1 ? a - b : op == 2'd2 ? a ^ b : a;
    endfunction

    // behavioural FPALU: result appears LATENCY cycles after the issue cycle
    always @(posedge clk) begin
        alu_pipe[0] <= alu_fn(alu_opcode, alu_a, alu_b);
        for (int k = 1; k < LATENCY; k++) alu_pipe[k] <= alu_pipe[k-1];
    end
    assign alu_y = alu_pipe[LATENCY-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit has(input logic [NREQ-1:0] v, input int j);
        return |(v & (NREQ'(1) << j));
    endfunction

    function automatic int pick(input logic [NREQ-1:0] v);
        if (rst) return -1;
        if (locked) return has(v, owner) ? owner : -1;
        for (int k = 0; k < NREQ; k++)
            if (has(v, (ptr + k) % NREQ)) return (ptr + k) % NREQ;
        return -1;
    endfunction

    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ-1:0] l);
        int g;
        logic [1:0] gi;
        if (rand_ops)
            for (int i = 0; i < NREQ; i++) begin
                op_c[i] = 2'($urandom);
                op_a[i] = DW'($urandom);
                op_b[i] = DW'($urandom);
            end
        bus.req_valid = v;
        bus.req_lock = l;
        bus.req_opcode = {op_c[2], op_c[1], op_c[0]};
        bus.req_a = {op_a[2], op_a[1], op_a[0]};
        bus.req_b = {op_b[2], op_b[1], op_b[0]};
        #1;
        g = pick(v);
        gi = 2'(g);
        check("req_ready", 64'(bus.req_ready), g < 0 ? 64'd0 : 64'd1 << g);
        check("alu_issue", 64'(alu_issue), 64'(m_issue));
        check("alu_opcode", 64'(alu_opcode), 64'(m_op));
        check("alu_a", 64'(alu_a), 64'(m_a));
        check("alu_b", 64'(alu_b), 64'(m_b));
        check("err_lock_timeout", 64'(err_lock_timeout), 64'(m_err));
        if (rq.size() > 0 && rq[0].due == cyc) begin
            check("rsp_valid", 64'(bus.rsp_valid), 64'd1 << rq[0].id);
            check("rsp_data", 64'(bus.rsp_data), 64'(rq[0].y));
            void'(rq.pop_front());
        end else
            check("rsp_valid_idle", 64'(bus.rsp_valid), 64'd0);
        @(posedge clk);
        cyc++;
        if (rst) begin
            ptr = 0; locked = 0; cnt = 0; m_err = 0;
            m_issue = 0; m_op = '0; m_a = '0; m_b = '0;
            rq.delete();
        end else begin
            m_issue = g >= 0;
            if (g >= 0) begin
                m_op = op_c[gi];
                m_a = op_a[gi];
                m_b = op_b[gi];
                rq.push_back('{cyc + 1 + LATENCY, g, alu_fn(m_op, m_a, m_b)});
                if (!locked) begin
                    ptr = (g + 1) % NREQ;
                    if (l[gi]) begin locked = 1; owner = g; cnt = 1; end
                end else if (!l[gi])
                    locked = 0;
                else begin
                    cnt++;
                    if (cnt == LOCK_MAX) begin locked = 0; m_err = 1; end
                end
            end
        end
        last_g = g;
        @(negedge clk);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_lock = '0;
        bus.req_opcode = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        // all requesters valid: grants rotate 0,1,2,...
        repeat (6) step(3'b111, 3'b000);
        repeat (8) step(3'b000, 3'b000);
        // single request with fixed operands, ALU passes a through
        rand_ops = 1'b0;
        for (int i = 0; i < NREQ; i++) begin op_c[i] = 2'b11; op_a[i] = 29'h0A00_0001; op_b[i] = 29'h1234; end
        step(3'b010, 3'b000);
        check("single_grant", 64'(last_g), 64'd1);
        repeat (7) step(3'b000, 3'b000);
        rand_ops = 1'b1;
        // locked burst by requester 2 while others wait
        repeat (4) begin step(3'b111, 3'b100); check("burst_grant", 64'(last_g), 64'd2); end
        step(3'b111, 3'b000);
        check("burst_last", 64'(last_g), 64'd2);
        step(3'b111, 3'b000);
        check("after_burst", 64'(last_g), 64'd0);
        check("burst_no_err", 64'(err_lock_timeout), 64'd0);
        repeat (6) step(3'b000, 3'b000);
        // lock held forever by requester 0 hits the timeout
        step(3'b001, 3'b001);
        repeat (LOCK_MAX - 1) step(3'b111, 3'b001);
        step(3'b111, 3'b001);
        check("timeout_next", 64'(last_g), 64'd1);
        repeat (6) step(3'b000, 3'b000);
        check("err_sticky", 64'(err_lock_timeout), 64'd1);
        // reset with operations in flight
        repeat (3) step(3'b111, 3'b000);
        rst = 1'b1;
        step(3'b111, 3'b000);
        rst = 1'b0;
        check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        repeat (6) step(3'b000, 3'b000);
        step(3'b111, 3'b000);
        check("first_after_rst", 64'(last_g), 64'd0);
        // requester 0 alternating, requester 2 always valid
        for (int k = 0; k < 8; k++) begin
            step(k % 2 == 0 ? 3'b101 : 3'b100, 3'b000);
            check("alt_not_1", 64'(last_g == 1), 64'd0);
        end
        repeat (6) step(3'b000, 3'b000);
        // random traffic with occasional locks and resets
        for (int k = 0; k < 800; k++) begin
            rst = $urandom_range(0, 99) == 0;
            step(3'($urandom), $urandom_range(0, 3) == 0 ? 3'($urandom) : 3'b000);
        end
        rst = 1'b0;
        repeat (8) step(3'b000, 3'b000);
        check("queue_drained", 64'(rq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fpalu_arbiter.md
# fpalu_arbiter

Round-robin arbiter and issue sequencer that shares one pipelined FPALU between NREQ requesters (FIR control engine, host debug port, spare accelerator). It sits in front of the FPALU, registers the winning operand pair and opcode, and tracks in-flight operations in a tag pipeline so every result returns to its originating requester. A lock mechanism lets a requester own the ALU for an uninterrupted burst, such as an accumulate chain, with a bounded hold time.

## Interface
- NREQ, 3 — number of requesters (2..4)
- DW, 29 — operand/result width (FP29i: sign, 6b exp, 22b mantissa)
- LATENCY, 4 — FPALU issue-to-result cycles (≥1)
- LOCK_MAX, 64 — max consecutive accepted requests while locked
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  request present, per requester
- req_lock  in  NREQ  keep grant after this request
- req_opcode  in  2*NREQ  per-requester opcode, slice i = [2i+1:2i]
- req_a, req_b  in  DW*NREQ  per-requester operands, slice i
- req_ready  out  NREQ  accept strobe, at most one bit set
- alu_issue  out  1  alu_* registered fields valid this cycle
- alu_opcode  out  2  to FPALU
- alu_a, alu_b  out  DW  to FPALU
- alu_y  in  DW  FPALU result, LATENCY cycles after issue
- rsp_valid  out  NREQ  one-hot result strobe
- rsp_data  out  DW  result, shared across requesters
- err_lock_timeout  out  1  sticky, forced lock release occurred

## Operation
- Acceptance: request i accepted when req_valid[i] & req_ready[i] at a rising edge; no backpressure on responses.
- FSM states:
  - ARB: req_ready one-hot to first valid requester at or after rr_ptr (wrapping). On accept, rr_ptr ← winner+1 mod NREQ; if req_lock[winner], go to LOCKED(owner=winner) with lock_cnt ← 1.
  - LOCKED: req_ready only to owner. Accepted owner request with req_lock=0 → ARB, rr_ptr ← owner+1. Accepted with req_lock=1 increments lock_cnt. If lock_cnt reaches LOCK_MAX on an accept → ARB and err_lock_timeout ← 1.
  - Owner dropping req_valid keeps the lock; other requesters starve until release or timeout.
- Tag pipeline: LATENCY+1 stages of {valid, id}, loaded on issue and advanced every cycle.
- Opcode/operands pass unmodified; no width conversion.
- Reset: rr_ptr=0, state=ARB, lock_cnt=0, tag pipe cleared, err_lock_timeout=0. All outputs 0: req_ready, alu_issue, alu_opcode, alu_a, alu_b, rsp_valid, rsp_data.
- Reset mid-operation: in-flight operations are discarded; no rsp_valid is produced for them after reset.

## Timing
- req_ready is combinational from req_valid, state and rr_ptr, with no dependency on req_opcode, req_a or req_b.
- Accept at edge T:
  - alu_issue=1 with the operands and opcode during cycle T+1.
  - FPALU result on alu_y during cycle T+1+LATENCY.
  - rsp_valid[id]/rsp_data registered, visible in cycle T+2+LATENCY.
- Throughput: one accept per cycle, back-to-back across or within requesters.
- No accept at edge T → alu_issue=0 in T+1; alu_a, alu_b, alu_opcode hold their last values.
- rsp_valid order equals accept order.
- Simultaneous valids: a single winner per cycle; losers hold req_valid, with no implicit queuing.
- Lock release and another requester's grant never occur in the same cycle; the earliest grant to another requester is the cycle after release.

## Test plan
- Reset, then NREQ=3, all req_valid=1 held 6 cycles → grants 0,1,2,0,1,2. alu_issue continuous from cycle 2. rsp_valid one-hot in the same order, first at cycle 7 (LATENCY=4).
- Requester 1 alone, req_a=29'h0A00_0001, opcode=2'b11, model ALU y=a → rsp_valid=3'b010 with rsp_data=29'h0A00_0001 exactly 6 cycles after accept.
- Requester 2 lock burst:
  - Stimulus: 5 requests (lock=1,1,1,1,0) while 0 and 1 stay valid.
  - Required: 5 consecutive grants to 2, then grant to 0; err_lock_timeout=0.
- LOCK_MAX=4, requester 0 holds lock=1 continuously → 4 grants to 0, then grant to 1; err_lock_timeout=1 and stays 1 until rst.
- Assert rst with 3 operations in flight → all outputs 0 next cycle. No rsp_valid for the flushed operations. First grant after reset goes to requester 0.
- Requester 0 requests alternately with requester 2 valid always → grant pattern 0,2,0,2; requester 1 never readied; rr_ptr wraps from 2 to 0 correctly.
